imm_ctrl: RTL and testbench
===========================

# imm_ctrl

Decode-side controller for the immediate path. It accepts fetched instructions over a valid/ready handshake, classifies the opcode into an immediate type, and builds the five sign-extended candidate immediates (J/U/B/S/I). It then selects and registers the chosen immediate. Output is a registered, skid-buffered stage between fetch and execute, so the core can stall or flush the immediate path without combinational ready chains.

## Interface

- `REG_LEN`, 32: datapath width. Immediates are sign-extended to `REG_LEN`. Values below 32 are illegal.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage can accept.
- `in_instr` in 32: RV32I instruction word.
- `in_pc` in `REG_LEN`: PC of `in_instr`.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: downstream accepts.
- `out_imm` out `REG_LEN`: selected immediate.
- `out_imm_type` out 3: `IMM_J`=1, `IMM_U`=2, `IMM_B`=3, `IMM_S`=4, `IMM_I`=5, none=0.
- `out_pc` out `REG_LEN`: PC passed through.
- `out_instr` out 32: instruction passed through.
- `out_illegal` out 1: opcode not recognised.

## Operation

- Opcode `in_instr[6:0]` to type:
  - 0110111 (LUI) and 0010111 (AUIPC): U.
  - 1101111 (JAL): J.
  - 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM), 1110011 (SYSTEM), 0001111 (MISC-MEM): I.
  - 1100011: B.
  - 0100011: S.
  - 0110011 (OP): none, imm=0.
  - Any other opcode: none, imm=0, `illegal`=1.
- Immediate formats (RV32I):
  - I = sext(`instr[31:20]`).
  - S = sext({`[31:25]`, `[11:7]`}).
  - B = sext({`[31]`, `[7]`, `[30:25]`, `[11:8]`, 0}).
  - U = {`[31:12]`, 12'b0}, sign-extended above bit 31 when `REG_LEN`>32.
  - J = sext({`[31]`, `[19:12]`, `[20]`, `[30:21]`, 0}).
  - Shift-immediates are not special-cased: funct7 bits stay in the I immediate.
- Two entries: main (drives `out_*`) and skid. `in_ready` = !skid_valid, driven straight from a register.
- Accept = `in_valid` & `in_ready`. Retire = `out_valid` & `out_ready`.
- Entry updates per edge, with flush=0:
  - main empty, or retire with skid empty: accepted entry loads main.
  - retire with skid full: skid moves to main, and any accept loads skid. The accept is impossible here because `in_ready`=0.
  - main full, no retire, accept: accepted entry loads skid.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- While `out_valid`=0, the `out_*` data fields hold their last value and are don't-care. After reset they read 0.

## Timing

- Reset (`rst_n`=0, asynchronous) forces:
  - `out_valid`=0, skid_valid=0, `in_ready`=1.
  - `out_imm`, `out_imm_type`, `out_pc`, `out_instr`, `out_illegal` all 0.
- Reset mid-operation discards both entries immediately.
- Latency is 1 cycle: an accept at edge N gives `out_valid`=1 after edge N.
- Throughput is 1 per cycle while `out_ready`=1. `in_ready` stays 1 in that case.
- If `out_ready` falls while streaming, one further instruction is absorbed into skid. `in_ready` is 0 from the next cycle.
- `in_ready` returns to 1 one cycle after the retire that empties skid.
- `flush`=1 at an edge:
  - both valids clear. An input presented that cycle is discarded even if `in_ready`=1.
  - `in_ready`=1 and `out_valid`=0 after the edge.
  - flush wins over simultaneous accept and retire. The downstream must ignore `out_valid` in the flush cycle.
- `out_valid` must not drop without a retire or a flush.
- `out_*` data must stay stable while `out_valid`=1 and `out_ready`=0.

## Test plan

- Reset values: hold `rst_n`=0, `in_valid`=1 with random data, and toggle `clk`. All outputs stay 0 and `in_ready`=1. Release reset at a non-edge time: first accept appears 1 cycle after.
- Immediate decode, `out_ready`=1:
  - `0xFFF00093` (ADDI) → imm `0xFFFFFFFF`, type 5.
  - `0x123452B7` (LUI) → imm `0x12345000`, type 2.
  - `0xFFDFF06F` (JAL -4) → imm `0xFFFFFFFC`, type 1.
  - `0x0020A423` (SW) → imm `0x00000008`, type 4.
  - `0x00000863` (BEQ +16) → imm `0x00000010`, type 3.
- Illegal and R-type: `0x00000000` → illegal=1, type 0, imm 0. `0x002081B3` (ADD) → illegal=0, type 0, imm 0.
- Back-pressure: stream 8 instructions with PCs 0, 4, …, 28 and drop `out_ready` for 3 cycles mid-stream.
  - exactly one extra instruction is accepted, then `in_ready`=0.
  - all 8 retire in order with matching `out_pc`. None is lost or duplicated.
- Flush:
  - with both entries full and `in_valid`=1, assert flush for 1 cycle. Next cycle: `out_valid`=0, `in_ready`=1, and the flush-cycle input is never output.
  - flush while empty has no effect.
- Random soak: 10k cycles of random `in_valid`, `out_ready` and flush (5%). A scoreboard confirms FIFO order, per-opcode imm/type correctness, and data stability under stall.

Source files
------------

// File: rtl/imm_ctrl.sv
// Immediate-path decode stage: classifies the opcode, builds the RV32I immediate, and registers it with a skid entry.
// Latency: 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready=1.
// Backpressure: a main entry and a skid entry; in_ready is a flop (high = skid empty), so no combinational ready path exists.
module imm_ctrl #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [REG_LEN-1:0] in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_LEN-1:0] out_imm,
  output logic [2:0]         out_imm_type,
  output logic [REG_LEN-1:0] out_pc,
  output logic [31:0]        out_instr,
  output logic               out_illegal
);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_J    = 3'd1;
  localparam logic [2:0] IMM_U    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_S    = 3'd4;
  localparam logic [2:0] IMM_I    = 3'd5;

  typedef struct packed {
    logic [REG_LEN-1:0] imm;
    logic [2:0]         imm_type;
    logic [REG_LEN-1:0] pc;
    logic [31:0]        instr;
    logic               illegal;
  } entry_t;

  logic   [6:0]         opcode;
  logic   [REG_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t               dec;
  entry_t               main_q, skid_q;
  logic                 main_valid;
  logic                 accept, retire;

  assign opcode = in_instr[6:0];

  // Sign extension comes from casting a signed operand up to REG_LEN.
  assign imm_i = REG_LEN'($signed(in_instr[31:20]));
  assign imm_s = REG_LEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = REG_LEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = REG_LEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = REG_LEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  // Classify the opcode and select the matching candidate immediate.
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.instr    = in_instr;
    dec.imm_type = IMM_NONE;
    dec.imm      = '0;
    dec.illegal  = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        dec.imm_type = IMM_U;
        dec.imm      = imm_u;
      end
      7'b1101111: begin
        dec.imm_type = IMM_J;
        dec.imm      = imm_j;
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: begin
        dec.imm_type = IMM_I;
        dec.imm      = imm_i;
      end
      7'b1100011: begin
        dec.imm_type = IMM_B;
        dec.imm      = imm_b;
      end
      7'b0100011: begin
        dec.imm_type = IMM_S;
        dec.imm      = imm_s;
      end
      7'b0110011: begin
        dec.imm_type = IMM_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // in_ready doubles as the "skid empty" flag, so accept never sees a full skid.
  assign accept = in_valid & in_ready;
  assign retire = main_valid & out_ready;

  // Main/skid entry update; flush beats any simultaneous accept or retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      in_ready   <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (!main_valid || (retire && in_ready)) begin
      main_valid <= accept;
      if (accept) begin
        main_q <= dec;
      end
    end else if (retire) begin
      // Skid is full here, so in_ready was low and nothing can be accepted.
      main_q   <= skid_q;
      in_ready <= 1'b1;
    end else if (accept) begin
      skid_q   <= dec;
      in_ready <= 1'b0;
    end
  end

  assign out_valid    = main_valid;
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.imm_type;
  assign out_pc       = main_q.pc;
  assign out_instr    = main_q.instr;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_ctrl.sv
// Bench for imm_ctrl: directed decode, back-pressure, flush and random soak.
// Reference is a depth-2 FIFO queue plus an arithmetic RV32I immediate decoder.
// Outputs are sampled 1 time unit after each rising edge.
module tb_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_illegal;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  ty;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ret_pcs[$];

  imm_ctrl #(.REG_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_imm_type(out_imm_type), .out_pc(out_pc), .out_instr(out_instr),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: arithmetic on a signed 32-bit view of the word.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   s;
    int   sign;
    s    = int'(w);
    sign = s >>> 31;  // 0 or -1
    e.pc = pc; e.instr = w; e.ill = 1'b0; e.ty = 3'd0; e.imm = 32'd0;
    case (w[6:0])
      7'h37, 7'h17: begin e.ty = 3'd2; e.imm = w & 32'hFFFF_F000; end
      7'h6F: begin
        e.ty  = 3'd1;
        e.imm = 32'((sign << 20) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1));
      end
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: begin e.ty = 3'd5; e.imm = 32'(s >>> 20); end
      7'h63: begin
        e.ty  = 3'd3;
        e.imm = 32'((sign << 12) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1));
      end
      7'h23: begin e.ty = 3'd4; e.imm = 32'(((s >>> 25) << 5) + int'(w[11:7])); end
      7'h33: e.ty = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F, 7'h63, 7'h23, 7'h33, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".imm"}, 64'(out_imm), 64'(q[0].imm));
      chk({tag, ".type"}, 64'(out_imm_type), 64'(q[0].ty));
      chk({tag, ".pc"}, 64'(out_pc), 64'(q[0].pc));
      chk({tag, ".instr"}, 64'(out_instr), 64'(q[0].instr));
      chk({tag, ".illegal"}, 64'(out_illegal), 64'(q[0].ill));
    end
  endtask

  // One clock edge: advance the reference with pre-edge inputs, then compare.
  task automatic cycle(input string tag);
    logic acc, ret;
    exp_t e;
    acc = in_valid && (q.size() < 2);
    ret = (q.size() > 0) && out_ready;
    e   = ref_decode(in_instr, in_pc);
    if (out_valid && out_ready && !flush) ret_pcs.push_back(out_pc);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_outputs(tag);
  endtask

  logic [31:0] dir_instr [7];
  logic [31:0] dir_imm   [7];
  logic [2:0]  dir_type  [7];
  logic        dir_ill   [7];
  int          idx;
  int          stall_acc;

  initial begin
    dir_instr = '{32'hFFF00093, 32'h123452B7, 32'hFFDFF06F, 32'h0020A423, 32'h00000863, 32'h00000000, 32'h002081B3};
    dir_imm   = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'h00000010, 32'h0, 32'h0};
    dir_type  = '{3'd5, 3'd2, 3'd1, 3'd4, 3'd3, 3'd0, 3'd0};
    dir_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset holds everything at zero while inputs and clock are active.
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = $urandom; in_pc = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_instr = $urandom; in_pc = $urandom;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.data", {out_imm, out_pc}, 64'd0);
      chk("rst.misc", {out_instr, out_imm_type, out_illegal}, 64'd0);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    in_instr = 32'hFFF00093; in_pc = 32'h100;
    cycle("first_accept");
    chk("first_accept.valid", 64'(out_valid), 64'd1);

    // Directed decode with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      in_instr = dir_instr[i]; in_pc = 32'(i * 4);
      cycle("decode");
      chk("decode.imm_const", 64'(out_imm), 64'(dir_imm[i]));
      chk("decode.type_const", 64'(out_imm_type), 64'(dir_type[i]));
      chk("decode.ill_const", 64'(out_illegal), 64'(dir_ill[i]));
    end
    in_valid = 1'b0;
    cycle("drain");
    cycle("drain");

    // Back-pressure: 8 instructions, out_ready low for 3 cycles mid-stream.
    ret_pcs.delete();
    idx = 0; stall_acc = 0;
    for (int c = 0; c < 40 && ret_pcs.size() < 8; c++) begin
      in_valid  = (idx < 8);
      in_instr  = rand_instr();
      in_pc     = 32'(idx * 4);
      out_ready = !(c >= 3 && c < 6);
      if (in_valid && in_ready) begin
        idx++;
        if (c >= 3 && c < 6) stall_acc++;
      end
      cycle("bp");
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.extra_accepts", 64'(stall_acc), 64'd1);
    chk("bp.retired", 64'(ret_pcs.size()), 64'd8);
    for (int i = 0; i < ret_pcs.size(); i++) chk("bp.order", 64'(ret_pcs[i]), 64'(i * 4));

    // Flush with both entries full and a pending input.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = rand_instr(); in_pc = 32'hA0; cycle("fill");
    in_instr = rand_instr(); in_pc = 32'hA4; cycle("fill");
    chk("fill.full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_instr = rand_instr(); in_pc = 32'hDEAD;
    cycle("flush");
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle("post_flush");
    cycle("post_flush");
    // Flush while empty, with and without an input presented.
    flush = 1'b1; cycle("flush_empty");
    in_valid = 1'b1; cycle("flush_empty_in");
    flush = 1'b0; in_valid = 1'b0; cycle("flush_empty_after");

    // Random soak with one asynchronous reset mid-run.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) < 5);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      if (c == 5000) begin
        #2 rst_n = 1'b0; q.delete();
        #1;
        chk("soak.rst_valid", 64'(out_valid), 64'd0);
        chk("soak.rst_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;
      end
      cycle("soak");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
